// File: rtl/minbd_pkg.sv
// Shared constants for the MinBD router pipeline: flit geometry and link port indices.
package minbd_pkg;
    localparam int FLIT_W    = 11;
    localparam int LOCAL_BIT = FLIT_W - 1;
    localparam int NPORTS    = 4;
    localparam int PTR_W     = 2;
    localparam int P_N       = 0;
    localparam int P_S       = 1;
    localparam int P_E       = 2;
    localparam int P_W       = 3;
endpackage

// File: rtl/eject_fifo.sv
// Ejection FIFO: DEPTH x W circular buffer, show-ahead head, push/pop in the same cycle allowed.
module eject_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks +push -pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign dout  = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/eject_arbiter.sv
// Per-router ejection controller: round-robin grant of one local-bound flit per cycle
// into an ejection FIFO; all other flits go through one register stage to deflection.
// Optional build macro EJECT_STATS_EN adds saturating grant/deflection counters.
module eject_arbiter #(
    parameter int FLIT_W = minbd_pkg::FLIT_W,
    parameter int DEPTH  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [minbd_pkg::NPORTS-1:0][FLIT_W-1:0] in_flit,
    input  logic [minbd_pkg::NPORTS-1:0]         in_vld,
    output logic [minbd_pkg::NPORTS-1:0][FLIT_W-1:0] out_flit,
    output logic [minbd_pkg::NPORTS-1:0]         out_vld,
    output logic [FLIT_W-1:0]                    lad,
    output logic                                 lad_vld,
    input  logic                                 lad_rdy,
`ifdef EJECT_STATS_EN
    output logic [15:0]                          stat_ej,
    output logic [15:0]                          stat_defl,
`endif
    output logic                                 ej_full
);
    import minbd_pkg::*;

    localparam int LB = FLIT_W - 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [NPORTS-1:0] cand;
    logic [NPORTS-1:0] gnt_mask;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  gnt_idx;
    logic [PTR_W-1:0]  idx;
    logic              gnt_found;
    logic              grant;
    logic              pop;
    logic              push_ok;
    logic              fifo_empty;
    logic [CW-1:0]     ej_cnt;

    assign pop     = lad_vld & lad_rdy;
    assign push_ok = (ej_cnt < CW'(DEPTH)) | pop;
    assign lad_vld = ~fifo_empty;

    // Candidate detection and rotating first-match search starting at rr_ptr.
    always_comb begin
        cand      = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int p = 0; p < NPORTS; p++) begin
            cand[p] = in_vld[p] & in_flit[p][LB];
        end
        for (int i = 0; i < NPORTS; i++) begin
            idx = rr_ptr + PTR_W'(i);
            if (!gnt_found && cand[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    // A grant only happens when the FIFO can take the flit this cycle.
    always_comb begin
        grant    = gnt_found & push_ok;
        gnt_mask = '0;
        if (grant) gnt_mask[gnt_idx] = 1'b1;
    end

    // Pass-through stage and round-robin pointer; only valids are masked by the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_flit <= '0;
            out_vld  <= '0;
            rr_ptr   <= '0;
        end else begin
            out_flit <= in_flit;
            out_vld  <= in_vld & ~gnt_mask;
            if (grant) rr_ptr <= gnt_idx + 1'b1;
        end
    end

    eject_fifo #(
        .W     (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .din   (in_flit[gnt_idx]),
        .pop   (pop),
        .dout  (lad),
        .full  (ej_full),
        .empty (fifo_empty),
        .count (ej_cnt)
    );

`ifdef EJECT_STATS_EN
    // Saturating counters: grants, and cycles where a local flit was deflected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ej   <= '0;
            stat_defl <= '0;
        end else begin
            if (grant && stat_ej != 16'hFFFF) stat_ej <= stat_ej + 16'd1;
            if (|cand && !grant && stat_defl != 16'hFFFF) stat_defl <= stat_defl + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_eject_arbiter.sv
// Directed bench for eject_arbiter; define EJECT_STATS_EN to also check the counters.
module tb_eject_arbiter;
    import minbd_pkg::*;

    localparam int FW = 11;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [NPORTS-1:0][FW-1:0]  in_flit = '0;
    logic [NPORTS-1:0]          in_vld = '0;
    logic [NPORTS-1:0][FW-1:0]  out_flit;
    logic [NPORTS-1:0]          out_vld;
    logic [FW-1:0]              lad;
    logic                       lad_vld;
    logic                       lad_rdy = 1'b0;
    logic                       ej_full;
`ifdef EJECT_STATS_EN
    logic [15:0]                stat_ej;
    logic [15:0]                stat_defl;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [FW-1:0] f [5];

    eject_arbiter #(.FLIT_W(FW), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_vld    (in_vld),
        .out_flit  (out_flit),
        .out_vld   (out_vld),
        .lad       (lad),
        .lad_vld   (lad_vld),
        .lad_rdy   (lad_rdy),
`ifdef EJECT_STATS_EN
        .stat_ej   (stat_ej),
        .stat_defl (stat_defl),
`endif
        .ej_full   (ej_full)
    );

    always #5 clk = ~clk;

    // One comparison: count it, report a mismatch.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_vld = '0;
        lad_rdy = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        // 1: reset release, idle
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("t1_out_vld", 64'(out_vld), 64'h0);
        chk("t1_lad_vld", 64'(lad_vld), 64'h0);
        chk("t1_rr_ptr",  64'(dut.rr_ptr), 64'h0);
        chk("t1_ej_full", 64'(ej_full), 64'h0);

        // 2: single eject on E, others non-local
        in_flit[P_N] = 11'h0AA;
        in_flit[P_S] = 11'h055;
        in_flit[P_E] = 11'b10100100100;
        in_flit[P_W] = 11'h123;
        in_vld  = 4'b1111;
        lad_rdy = 1'b1;
        tick();
        chk("t2_out_vld", 64'(out_vld), 64'hB);
        chk("t2_lad",     64'(lad), 64'h524);
        chk("t2_lad_vld", 64'(lad_vld), 64'h1);
        chk("t2_out_w",   64'(out_flit[P_W]), 64'h123);
        chk("t2_out_e",   64'(out_flit[P_E]), 64'h524);
        chk("t2_rr_ptr",  64'(dut.rr_ptr), 64'h3);
        in_vld = '0;
        tick();
        chk("t2_drained", 64'(lad_vld), 64'h0);

        // 3: round-robin, all four local
        do_reset();
        for (int p = 0; p < NPORTS; p++) in_flit[p] = 11'h400 | 11'(p * 17 + 1);
        in_vld  = 4'b1111;
        lad_rdy = 1'b1;
        for (int k = 0; k < NPORTS; k++) begin
            tick();
            chk($sformatf("t3_out_vld%0d", k), 64'(out_vld), 64'(4'b1111 & ~(4'b0001 << k)));
            chk($sformatf("t3_lad%0d", k),     64'(lad), 64'(11'h400 | 11'(k * 17 + 1)));
        end
        in_vld = '0;
        tick();
        chk("t3_drained", 64'(lad_vld), 64'h0);

        // 4: fill the FIFO from N with no drain; fifth flit deflects
        do_reset();
        for (int k = 0; k < 5; k++) f[k] = 11'h400 | 11'(8'h30 + k);
        in_vld = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            in_flit[P_N] = f[k];
            tick();
            chk($sformatf("t4_out_vld%0d", k), 64'(out_vld), 64'h0);
            chk($sformatf("t4_rr%0d", k),      64'(dut.rr_ptr), 64'h1);
        end
        chk("t4_full4", 64'(ej_full), 64'h1);
        in_flit[P_N] = f[4];
        tick();
        chk("t4_out_vld5", 64'(out_vld), 64'h1);
        chk("t4_out_n5",   64'(out_flit[P_N]), 64'(f[4]));
        chk("t4_full5",    64'(ej_full), 64'h1);
        chk("t4_rr5",      64'(dut.rr_ptr), 64'h1);
        chk("t4_lad",      64'(lad), 64'(f[0]));
`ifdef EJECT_STATS_EN
        chk("t4_stat_ej",   64'(stat_ej), 64'd4);
        chk("t4_stat_defl", 64'(stat_defl), 64'd1);
`endif

        // 5: full FIFO with simultaneous pop accepts a W flit
        in_flit[P_W] = 11'h4EE;
        in_vld  = 4'b1000;
        lad_rdy = 1'b1;
        tick();
        chk("t5_out_vld", 64'(out_vld), 64'h0);
        chk("t5_full",    64'(ej_full), 64'h1);
        chk("t5_lad",     64'(lad), 64'(f[1]));
        chk("t5_rr",      64'(dut.rr_ptr), 64'h0);

        // 6: drain one to reach count 3, then reset mid-cycle
        in_vld = '0;
        tick();
        chk("t6_full3", 64'(ej_full), 64'h0);
        chk("t6_lad3",  64'(lad), 64'(f[2]));
        lad_rdy = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_lad_vld", 64'(lad_vld), 64'h0);
        chk("t6_async_out_vld", 64'(out_vld), 64'h0);
        tick();
        rst = 1'b0;
        in_flit[P_S] = 11'h5A5;
        in_vld = 4'b0010;
        tick();
        chk("t6_out_vld", 64'(out_vld), 64'h0);
        chk("t6_lad_vld", 64'(lad_vld), 64'h1);
        chk("t6_lad",     64'(lad), 64'h5A5);
        chk("t6_full",    64'(ej_full), 64'h0);
        in_vld = '0;
        tick();
        chk("t6_hold", 64'(lad), 64'h5A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
